hbridge_deadtime_ctrl: RTL and testbench

Parametrised gate-drive sequencer for N_BR full H-bridges of the converter power stage. Each bridge takes a three-level command (+1, 0, −1) and drives four gate signals, inserting a programmable dead time on every level change: only switches common to source and destination patterns conduct. It sits between the modulator and the gate-driver pins and adds per-bridge polarity, a registered glitch-free gate output, busy/level status and an optional latched emergency shutdown.

---
 rtl/hbridge_deadtime_ctrl.sv | 135 +++++++++++++
 tb/tb_hbridge_deadtime_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/hbridge_deadtime_ctrl.sv
// Dead-time gate sequencer for N_BR H-bridges: +1/0/-1 commands to 4 gates.
// Ports: clk, rst (async high), ce, deadtime, vcmd -> gates, level, busy;
// with HBRIDGE_FAULT_EN: fault_in, fault_clr -> fault_latched.
module hbridge_deadtime_ctrl #(
  parameter int              N_BR     = 2,
  parameter int              DT_W     = 8,
  parameter logic [N_BR-1:0] INV_MASK = 2'b10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic [DT_W-1:0]   deadtime,
  input  logic [2*N_BR-1:0] vcmd,
  output logic [4*N_BR-1:0] gates,
  output logic [2*N_BR-1:0] level,
  output logic [N_BR-1:0]   busy
`ifdef HBRIDGE_FAULT_EN
  ,
  input  logic              fault_in,
  input  logic              fault_clr,
  output logic              fault_latched
`endif
);

  // Level encoding: +1 = 2'b01, 0 = 2'b00, -1 = 2'b11, 2'b10 invalid.
  function automatic logic [3:0] pat(
    input logic [1:0] l,
    input logic       inv
  );
    logic [3:0] p;
    p = 4'b0101;
    case (l)
      2'b01:   p = inv ? 4'b1001 : 4'b0110;
      2'b11:   p = inv ? 4'b0110 : 4'b1001;
      default: p = 4'b0101;
    endcase
    return p;
  endfunction

  logic flt_trip;
  logic flt_rel;
  logic flt_hold;

`ifdef HBRIDGE_FAULT_EN
  // Trip is sampled on every edge; release needs an enabled edge.
  assign flt_trip = fault_in;
  assign flt_rel  = fault_latched & ~fault_in & fault_clr & ce;
  assign flt_hold = fault_latched;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_latched <= 1'b0;
    end else if (fault_in) begin
      fault_latched <= 1'b1;
    end else if (flt_rel) begin
      fault_latched <= 1'b0;
    end
  end
`else
  assign flt_trip = 1'b0;
  assign flt_rel  = 1'b0;
  assign flt_hold = 1'b0;
`endif

  for (genvar i = 0; i < N_BR; i++) begin : g_br
    typedef enum logic {
      STEADY,
      DEAD
    } st_t;

    st_t             st;
    logic [1:0]      cur;
    logic [1:0]      dst;
    logic [1:0]      cmd;
    logic [DT_W-1:0] cnt;
    logic [3:0]      g;
    logic            b;

    assign cmd = vcmd[2*i +: 2];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        st  <= STEADY;
        cur <= 2'b00;
        dst <= 2'b00;
        cnt <= '0;
        g   <= 4'b0101;
        b   <= 1'b0;
      end else if (flt_trip) begin
        // All switches open; FSM state frozen.
        g <= 4'b0000;
        b <= 1'b0;
      end else if (flt_rel) begin
        // Leave the fault through an all-off window into level 0.
        st  <= DEAD;
        dst <= 2'b00;
        cnt <= '0;
        g   <= 4'b0000;
        b   <= 1'b1;
      end else if (flt_hold) begin
        g <= 4'b0000;
      end else if (ce) begin
        case (st)
          STEADY: begin
            if (cmd != 2'b10 && cmd != cur) begin
              st  <= DEAD;
              dst <= cmd;
              cnt <= '0;
              g   <= pat(cur, INV_MASK[i])
                   & pat(cmd, INV_MASK[i]);
              b   <= 1'b1;
            end
          end
          DEAD: begin
            if (cnt >= deadtime) begin
              st  <= STEADY;
              cur <= dst;
              cnt <= '0;
              g   <= pat(dst, INV_MASK[i]);
              b   <= 1'b0;
            end else if (cnt != {DT_W{1'b1}}) begin
              cnt <= cnt + 1'b1;
            end
          end
          default: st <= STEADY;
        endcase
      end
    end

    assign gates[4*i +: 4] = g;
    assign level[2*i +: 2] = cur;
    assign busy[i]         = b;
  end

endmodule

// File: tb/tb_hbridge_deadtime_ctrl.sv
// Directed bench for hbridge_deadtime_ctrl (N_BR=2, bridge 1 inverted).
// Expected gates/level/busy are queued per step and checked after the edge.
module tb_hbridge_deadtime_ctrl;

  logic       clk;
  logic       rst;
  logic       ce;
  logic [7:0] deadtime;
  logic [3:0] vcmd;
  logic [7:0] gates;
  logic [3:0] level;
  logic [1:0] busy;
`ifdef HBRIDGE_FAULT_EN
  logic       fault_in;
  logic       fault_clr;
  logic       fault_latched;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string      tag;
    logic [7:0] g;
    logic [3:0] lv;
    logic [1:0] b;
  } exp_t;

  exp_t sb[$];

  hbridge_deadtime_ctrl #(
    .N_BR(2),
    .DT_W(8),
    .INV_MASK(2'b10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ce(ce),
    .deadtime(deadtime),
    .vcmd(vcmd),
    .gates(gates),
    .level(level),
    .busy(busy)
`ifdef HBRIDGE_FAULT_EN
    ,
    .fault_in(fault_in),
    .fault_clr(fault_clr),
    .fault_latched(fault_latched)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Push expectation, optionally advance one edge, then pop and compare.
  task automatic chk(
    input string      tag,
    input logic [7:0] g,
    input logic [3:0] lv,
    input logic [1:0] b,
    input bit         edge_
  );
    exp_t e;
    e.tag = tag;
    e.g   = g;
    e.lv  = lv;
    e.b   = b;
    sb.push_back(e);
    if (edge_) begin
      @(posedge clk);
      #1;
    end else begin
      #1;
    end
    e = sb.pop_front();
    checks++;
    assert (gates === e.g) else begin
      failures++;
      $error("FAIL %s gates got=%h exp=%h", e.tag, gates, e.g);
    end
    checks++;
    assert (level === e.lv) else begin
      failures++;
      $error("FAIL %s level got=%b exp=%b", e.tag, level, e.lv);
    end
    checks++;
    assert (busy === e.b) else begin
      failures++;
      $error("FAIL %s busy got=%b exp=%b", e.tag, busy, e.b);
    end
  endtask

`ifdef HBRIDGE_FAULT_EN
  task automatic chk_f(input string tag, input logic exp);
    checks++;
    assert (fault_latched === exp) else begin
      failures++;
      $error("FAIL %s fault_latched got=%b exp=%b",
             tag, fault_latched, exp);
    end
  endtask
`endif

  initial begin
    rst      = 1'b1;
    ce       = 1'b1;
    deadtime = 8'd3;
    vcmd     = 4'b0000;
`ifdef HBRIDGE_FAULT_EN
    fault_in  = 1'b0;
    fault_clr = 1'b0;
`endif
    #1;
    chk("reset", 8'h55, 4'b0000, 2'b00, 0);
`ifdef HBRIDGE_FAULT_EN
    chk_f("reset_flt", 1'b0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("idle", 8'h55, 4'b0000, 2'b00, 1);

    // Both bridges 0 -> +1, deadtime 3
    vcmd = 4'b0101;
    for (int k = 0; k < 4; k++)
      chk($sformatf("zp_dead%0d", k), 8'h14, 4'b0000, 2'b11, 1);
    chk("zp_land", 8'h96, 4'b0101, 2'b00, 1);

    // Bridge 0 +1 -> -1 direct, deadtime 0
    deadtime = 8'd0;
    vcmd = 4'b0111;
    chk("pm_dead", 8'h90, 4'b0101, 2'b01, 1);
    chk("pm_land", 8'h99, 4'b0111, 2'b00, 1);

    // Invalid command ignored
    vcmd = 4'b0110;
    chk("inv0", 8'h99, 4'b0111, 2'b00, 1);
    chk("inv1", 8'h99, 4'b0111, 2'b00, 1);

    // -1 -> 0 with ce 1-in-3 and a toggle mid-window
    deadtime = 8'd3;
    vcmd = 4'b0100;
    chk("ce_e0", 8'h91, 4'b0111, 2'b01, 1);
    vcmd = 4'b0101;
    for (int k = 1; k <= 3; k++) begin
      ce = 1'b0;
      chk($sformatf("ce_off%0da", k), 8'h91, 4'b0111, 2'b01, 1);
      chk($sformatf("ce_off%0db", k), 8'h91, 4'b0111, 2'b01, 1);
      ce = 1'b1;
      chk($sformatf("ce_on%0d", k), 8'h91, 4'b0111, 2'b01, 1);
    end
    ce = 1'b0;
    chk("ce_pre4a", 8'h91, 4'b0111, 2'b01, 1);
    chk("ce_pre4b", 8'h91, 4'b0111, 2'b01, 1);
    ce = 1'b1;
    chk("ce_land", 8'h95, 4'b0100, 2'b00, 1);
    ce = 1'b0;
    chk("ce_hold", 8'h95, 4'b0100, 2'b00, 1);
    ce = 1'b1;
    chk("new_e0", 8'h94, 4'b0100, 2'b01, 1);
    for (int k = 1; k <= 3; k++)
      chk($sformatf("new_dead%0d", k), 8'h94, 4'b0100, 2'b01, 1);
    chk("new_land", 8'h96, 4'b0101, 2'b00, 1);

    // deadtime 200 -> 5 with counter at 10
    deadtime = 8'd200;
    vcmd = 4'b0100;
    chk("dl_e0", 8'h94, 4'b0101, 2'b01, 1);
    for (int k = 1; k <= 10; k++)
      chk($sformatf("dl_dead%0d", k), 8'h94, 4'b0101, 2'b01, 1);
    deadtime = 8'd5;
    chk("dl_land", 8'h95, 4'b0100, 2'b00, 1);

    // Simultaneous transitions, deadtime 0
    deadtime = 8'd0;
    vcmd = 4'b1101;
    chk("sim_dead", 8'h04, 4'b0100, 2'b11, 1);
    chk("sim_land", 8'h66, 4'b1101, 2'b00, 1);

    // Maximum deadtime: 256-cycle window
    deadtime = 8'd255;
    vcmd = 4'b1100;
    chk("sat_e0", 8'h64, 4'b1101, 2'b01, 1);
    for (int k = 1; k <= 255; k++)
      chk($sformatf("sat_dead%0d", k), 8'h64, 4'b1101, 2'b01, 1);
    chk("sat_land", 8'h65, 4'b1100, 2'b00, 1);

    // Async reset mid-transition
    deadtime = 8'd3;
    vcmd = 4'b1101;
    chk("rst_e0", 8'h64, 4'b1100, 2'b01, 1);
    #2;
    rst = 1'b1;
    chk("rst_async", 8'h55, 4'b0000, 2'b00, 0);
    vcmd = 4'b0000;
    #1;
    rst = 1'b0;
    chk("rst_idle", 8'h55, 4'b0000, 2'b00, 1);

`ifdef HBRIDGE_FAULT_EN
    vcmd = 4'b0001;
    chk("f_e0", 8'h54, 4'b0000, 2'b01, 1);
    fault_in = 1'b1;
    chk("f_trip", 8'h00, 4'b0000, 2'b00, 1);
    chk_f("f_trip_l", 1'b1);
    fault_in = 1'b0;
    vcmd = 4'b0000;
    chk("f_hold", 8'h00, 4'b0000, 2'b00, 1);
    chk_f("f_hold_l", 1'b1);
    fault_in  = 1'b1;
    fault_clr = 1'b1;
    chk("f_both", 8'h00, 4'b0000, 2'b00, 1);
    chk_f("f_both_l", 1'b1);
    fault_in = 1'b0;
    chk("f_rel", 8'h00, 4'b0000, 2'b11, 1);
    chk_f("f_rel_l", 1'b0);
    fault_clr = 1'b0;
    for (int k = 1; k <= 3; k++)
      chk($sformatf("f_dead%0d", k), 8'h00, 4'b0000, 2'b11, 1);
    chk("f_land", 8'h55, 4'b0000, 2'b00, 1);
    chk_f("f_land_l", 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
